// File: rtl/rx_mem_loader_pkg.sv
// Shared constants for the UART image path: loader FSM encodings and default
// frame geometry, also used by the receiver and downsampler blocks.
package rx_mem_loader_pkg;

    localparam int DEF_IMAGE_BYTES = 65536;
    localparam int DEF_ADDR_W      = 16;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BYTE = 2'd1;
    localparam logic [1:0] ST_WRITE     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/rx_mem_loader_edge.sv
// Rising-edge detector for done-level handshakes; the registered level resets
// to RESET_LEVEL so a level already high coming out of reset is not an edge.
module edge_detect_rise #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic level_q_o,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= RESET_LEVEL;
        end else begin
            level_q <= level_i;
        end
    end

    assign level_q_o = level_q;
    assign rise_o    = level_i & ~level_q;

endmodule

// File: rtl/rx_mem_loader.sv
// Loads a fixed-size frame of UART bytes into image RAM, one write per byte,
// at consecutive addresses starting from 0 after each start pulse.
module rx_mem_loader
    import rx_mem_loader_pkg::*;
#(
    parameter int IMAGE_BYTES = DEF_IMAGE_BYTES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_done,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W:0] IMAGE_CNT = (ADDR_W+1)'(IMAGE_BYTES);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        byte_q, byte_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   count_inc;
    logic              rx_done_q;
    logic              rx_rise;

    edge_detect_rise #(.RESET_LEVEL(1'b1)) u_rx_edge (
        .clk       (clk),
        .rst       (rst),
        .level_i   (rx_done),
        .level_q_o (rx_done_q),
        .rise_o    (rx_rise)
    );

    assign count_inc = count_q + 1'b1;

    // The write address is always the running byte count, so it cannot wrap:
    // the FSM leaves WRITE for DONE before the count exceeds the frame size.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    count_d = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (rx_rise) begin
                    byte_d  = rx_byte;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = byte_q;
                count_d = count_inc;
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (count_inc == IMAGE_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            byte_q  <= byte_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign busy       = busy_q;
    assign load_done  = done_q;
    assign byte_count = count_q;

endmodule

// File: doc/rx_mem_loader.md
RX_MEM_LOADER -- requirements
Module: rx_mem_loader

Interface
REQ-001 Parameter IMAGE_BYTES, default 65536: bytes per frame to load, range 1..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 16: memory address width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports are listed below.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rx_byte  in  8  received byte from the UART receiver; valid when rx_done is high.
REQ-007 rx_done  in  1  receiver done level; goes high one cycle after a byte completes and stays high until the next start bit.
REQ-008 start  in  1  single-cycle pulse that arms a frame load.
REQ-009 abort  in  1  single-cycle pulse that cancels a load in progress.
REQ-010 mem_addr  out  ADDR_W  write address to the image RAM.
REQ-011 mem_wdata  out  8  write data to the image RAM.
REQ-012 mem_we  out  1  write strobe, one cycle per byte.
REQ-013 busy  out  1  high while a load is armed or in progress.
REQ-014 load_done  out  1  single-cycle pulse when the final byte of a frame is written.
REQ-015 byte_count  out  ADDR_W+1  number of bytes written in the current or last frame.

Function
REQ-016 The block SHALL implement the states IDLE, WAIT_BYTE, WRITE and DONE.
REQ-017 The block SHALL register rx_done into rx_done_q and detect a new byte as rx_done high while rx_done_q is low.
REQ-018 IDLE: start SHALL clear byte_count and the address to 0, set busy, and move to WAIT_BYTE on the next cycle.
REQ-019 IDLE: rx_done edges SHALL be ignored, with no write and no count change.
REQ-020 WAIT_BYTE: a detected edge SHALL capture rx_byte into mem_wdata and move to WRITE.
REQ-021 WRITE: the block SHALL assert mem_we for exactly one cycle with mem_addr equal to the current address, then increment the address and byte_count.
REQ-022 Latency from the rx_done edge to mem_we high SHALL be 2 cycles.
REQ-023 After WRITE, if byte_count equals IMAGE_BYTES the block SHALL go to DONE; otherwise it SHALL return to WAIT_BYTE.
REQ-024 DONE: the block SHALL pulse load_done for one cycle, clear busy, and return to IDLE.
REQ-025 The address SHALL never wrap: with IMAGE_BYTES = 2^ADDR_W, the last write is at address 2^ADDR_W-1 and byte_count reaches 2^ADDR_W without overflow, since it is ADDR_W+1 bits.
REQ-026 start while busy SHALL be ignored.
REQ-027 abort in WAIT_BYTE SHALL return the block to IDLE next cycle, clear busy, issue no load_done, and hold byte_count.
REQ-028 abort in WRITE SHALL let the pending write complete, then go to IDLE without load_done.
REQ-029 abort and start in the same cycle SHALL be treated as abort only.
REQ-030 abort and an rx_done edge in the same WAIT_BYTE cycle SHALL discard the byte.
REQ-031 mem_we SHALL be low in every state except WRITE.
REQ-032 mem_addr and mem_wdata SHALL hold their last values when mem_we is low.

Reset
REQ-033 On rst the block SHALL set state to IDLE; mem_addr, mem_wdata, mem_we, busy, load_done and byte_count to 0.
REQ-034 On rst rx_done_q SHALL be set to 1, so a rx_done already high after reset produces no edge.
REQ-035 rst asserted mid-frame SHALL abandon the frame, with no further write and no load_done.

Structure
REQ-036 State encodings and the default IMAGE_BYTES and ADDR_W SHALL reside in a shared package used by the receiver and the downsampler.
REQ-037 The rx_done edge detector SHALL be a separate sub-module, edge_detect_rise, which is reusable for other done-level handshakes.

Verification
REQ-038 Reset with rx_done held high, then start -> no write until rx_done falls and rises again.
REQ-039 IMAGE_BYTES=4, start, then bytes 0x11, 0x22, 0x33, 0x44 -> writes at addresses 0..3 with that data, load_done once, byte_count=4, busy low.
REQ-040 Bytes sent in IDLE (no start) -> mem_we stays 0 and byte_count is unchanged.
REQ-041 IMAGE_BYTES=4, abort after 2 bytes -> byte_count=2, no load_done; a following start reloads from address 0.
REQ-042 ADDR_W=2, IMAGE_BYTES=4 -> last write at address 3, byte_count=4, no wrap to 0.
REQ-043 rst asserted during WRITE of byte 2 -> all outputs 0 next cycle; the byte 2 write does not complete.
